// File: rtl/tlm_fifo_pkg.sv
// Shared definitions for the tlm_fifo channel: per-cycle handshake operation
// kinds and pointer sizing.
package tlm_fifo_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUT  = 2'b01,
      OP_GET  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   // A single-entry FIFO still needs a 1-bit pointer signal.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/tlm_fifo_if.sv
// Put/get handshake bundle plus occupancy status for one tlm_fifo instance.
interface tlm_fifo_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             put_valid;
   logic             put_ready;
   logic [WIDTH-1:0] put_data;
   logic             get_valid;
   logic             get_ready;
   logic [WIDTH-1:0] get_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;

   modport slave (
      input  put_valid, put_data, get_ready,
      output put_ready, get_valid, get_data, count, full, empty
   );

   modport master (
      output put_valid, put_data, get_ready,
      input  put_ready, get_valid, get_data, count, full, empty
   );
endinterface

// File: rtl/tlm_fifo_ptr.sv
// Modulo-DEPTH wrap counter used for the FIFO read and write pointers.
module tlm_fifo_ptr
   import tlm_fifo_pkg::*;
#(
   parameter int DEPTH = 3,
   localparam int PW   = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] r_ptr;

   // Explicit wrap so non-power-of-two depths never visit unused slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (inc) begin
         r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
      end
   end

   assign ptr = r_ptr;

endmodule

// File: rtl/tlm_fifo.sv
// Bounded in-order transaction FIFO with put/get valid-ready handshakes,
// registered-state flags and one cycle of write-to-read latency.
module tlm_fifo
   import tlm_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3
) (
   input  logic     clk,
   input  logic     rst,
   tlm_fifo_if.slave bus
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    w_wr_ptr;
   logic [PW-1:0]    w_rd_ptr;
   logic             w_full;
   logic             w_empty;
   logic             w_do_put;
   logic             w_do_get;
   fifo_op_e         w_op;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_do_put = bus.put_valid & ~w_full;
   assign w_do_get = bus.get_ready & ~w_empty;

   always_comb begin
      w_op = OP_IDLE;
      case ({w_do_get, w_do_put})
         2'b01:   w_op = OP_PUT;
         2'b10:   w_op = OP_GET;
         2'b11:   w_op = OP_BOTH;
         default: w_op = OP_IDLE;
      endcase
   end

   tlm_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (w_do_put),
      .ptr (w_wr_ptr)
   );

   tlm_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (w_do_get),
      .ptr (w_rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (!rst && w_do_put) begin
         r_mem[w_wr_ptr] <= bus.put_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         case (w_op)
            OP_PUT:  r_count <= r_count + 1'b1;
            OP_GET:  r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.put_ready = ~w_full;
   assign bus.get_valid = ~w_empty;
   assign bus.get_data  = r_mem[w_rd_ptr];
   assign bus.count     = r_count;
   assign bus.full      = w_full;
   assign bus.empty     = w_empty;

   a_count_max: assert property (@(posedge clk) disable iff (rst)
      r_count <= CW'(DEPTH));
   a_no_write_full: assert property (@(posedge clk) disable iff (rst)
      w_full |-> !w_do_put);
   a_no_read_empty: assert property (@(posedge clk) disable iff (rst)
      w_empty |-> !w_do_get);

endmodule

// File: tb/tb_tlm_fifo.sv
// Directed self-checking bench for tlm_fifo (WIDTH=32, DEPTH=3).
module tb_tlm_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 3;

   typedef struct {
      logic        rst;
      logic        pv;
      logic [31:0] pd;
      logic        gr;
      int          cnt;
      logic [31:0] gd;
      logic        chk_d;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   tlm_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   tlm_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic vec_t mk(input logic r, input logic pv, input logic [31:0] pd,
                               input logic gr, input int cnt, input logic [31:0] gd,
                               input logic chk_d);
      vec_t v;
      v.rst = r; v.pv = pv; v.pd = pd; v.gr = gr;
      v.cnt = cnt; v.gd = gd; v.chk_d = chk_d;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic pv, input logic [31:0] pd, input logic gr);
      @(negedge clk);
      rst           = r;
      bus.put_valid = pv;
      bus.put_data  = pd;
      bus.get_ready = gr;
   endtask

   task automatic chk_state(input string tag, input int cnt);
      chk({tag, ".count"},     32'(bus.count),     32'(cnt));
      chk({tag, ".full"},      32'(bus.full),      32'(cnt == DEPTH));
      chk({tag, ".empty"},     32'(bus.empty),     32'(cnt == 0));
      chk({tag, ".put_ready"}, 32'(bus.put_ready), 32'(cnt != DEPTH));
      chk({tag, ".get_valid"}, 32'(bus.get_valid), 32'(cnt != 0));
   endtask

   initial begin
      logic [31:0] rx[$];

      rst = 1'b1;
      bus.put_valid = 1'b0;
      bus.put_data  = '0;
      bus.get_ready = 1'b0;

      // reset
      vecs.push_back(mk(1, 0, 32'h0,  0, 0, 32'h0,  0));
      vecs.push_back(mk(1, 0, 32'h0,  0, 0, 32'h0,  0));
      // fill, refused put while full, drain, get while empty
      vecs.push_back(mk(0, 1, 32'hA1, 0, 1, 32'hA1, 1));
      vecs.push_back(mk(0, 1, 32'hA2, 0, 2, 32'hA1, 1));
      vecs.push_back(mk(0, 1, 32'hA3, 0, 3, 32'hA1, 1));
      vecs.push_back(mk(0, 1, 32'hA4, 0, 3, 32'hA1, 1));
      vecs.push_back(mk(0, 0, 32'h0,  1, 2, 32'hA2, 1));
      vecs.push_back(mk(0, 0, 32'h0,  1, 1, 32'hA3, 1));
      vecs.push_back(mk(0, 0, 32'h0,  1, 0, 32'h0,  0));
      vecs.push_back(mk(0, 0, 32'h0,  1, 0, 32'h0,  0));
      // full with simultaneous put+get: only the get happens
      vecs.push_back(mk(0, 1, 32'hB1, 0, 1, 32'hB1, 1));
      vecs.push_back(mk(0, 1, 32'hB2, 0, 2, 32'hB1, 1));
      vecs.push_back(mk(0, 1, 32'hB3, 0, 3, 32'hB1, 1));
      vecs.push_back(mk(0, 1, 32'hB4, 1, 2, 32'hB2, 1));
      vecs.push_back(mk(0, 1, 32'hB4, 0, 3, 32'hB2, 1));
      vecs.push_back(mk(0, 0, 32'h0,  1, 2, 32'hB3, 1));
      vecs.push_back(mk(0, 0, 32'h0,  1, 1, 32'hB4, 1));
      vecs.push_back(mk(0, 0, 32'h0,  1, 0, 32'h0,  0));
      // empty with simultaneous put+get: only the put happens
      vecs.push_back(mk(0, 1, 32'hC5, 1, 1, 32'hC5, 1));
      vecs.push_back(mk(0, 0, 32'h0,  1, 0, 32'h0,  0));

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         if (i == 0) begin
            @(negedge clk);
            chk_state("pre_reset_x", 0);
            n_checks = 0;
            n_fail   = 0;
         end
         drive(vecs[i].rst, vecs[i].pv, vecs[i].pd, vecs[i].gr);
         @(posedge clk);
         #1;
         chk_state(tag, vecs[i].cnt);
         if (vecs[i].chk_d) chk({tag, ".get_data"}, bus.get_data, vecs[i].gd);
      end

      // continuous streaming through the wrap point
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 32'(i), 1);
         if (bus.get_valid) rx.push_back(bus.get_data);
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d.count", i), 32'(bus.count), 32'd1);
      end
      drive(0, 0, 32'h0, 1);
      if (bus.get_valid) rx.push_back(bus.get_data);
      @(posedge clk);
      #1;
      chk("stream_end.count", 32'(bus.count), 32'd0);
      chk("stream.rx_size", 32'(rx.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("stream.rx%0d", i), (i < rx.size()) ? rx[i] : 32'hDEAD_BEEF, 32'(i));
      end

      // mid-operation reset discards held words and the put in the reset cycle
      drive(0, 1, 32'hE1, 0);
      drive(0, 1, 32'hE2, 0);
      @(posedge clk);
      #1;
      chk_state("mid_pre", 2);
      drive(1, 1, 32'hE3, 0);
      @(posedge clk);
      #1;
      chk_state("mid_rst", 0);
      drive(0, 1, 32'hD1, 0);
      @(posedge clk);
      #1;
      chk_state("mid_post", 1);
      chk("mid_post.get_data", bus.get_data, 32'hD1);
      drive(0, 0, 32'h0, 1);
      @(posedge clk);
      #1;
      chk_state("mid_drain", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
